mem_arbiter: RTL
================

# mem_arbiter

Shares the single memory port between the multi-cycle CPU and a host burst port used by the loader/debug link. The CPU owns memory by default. A host burst is granted only at an instruction boundary. While the burst runs, the CPU is frozen in its FETCH step via `cpu_stall`, and the arbiter sequences word addresses itself. The block sits between the CPU control/datapath memory signals and the memory.

## Interface
- `LEN_W`, 8: width of `host_len`. Bursts are 0..2^LEN_W-1 words.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cpu_step` in 2: CPU step counter (FETCH=0, DECODE=1, MEM=2, EXEC=3).
- `cpu_addr` in 32, `cpu_read_op` in 3, `cpu_write_op` in 2, `cpu_wdata` in 32: CPU memory request.
- `cpu_rdata` out 32: memory read data to the CPU.
- `cpu_stall` out 1: the CPU step counter holds its value while this is high.
- `host_req` in 1: burst request, level.
- `host_we` in 1: 1 = write burst, 0 = read burst.
- `host_addr` in 32: burst base address; bits [1:0] are ignored.
- `host_len` in LEN_W: burst length in words.
- `host_wdata` in 32: write word; must be valid whenever `host_wready` is high.
- `host_busy` out 1: burst accepted and not yet complete.
- `host_wready` out 1: write word consumed this cycle.
- `host_rvalid` out 1, `host_rdata` out 32: read word returned.
- `host_done` out 1: one-cycle pulse at burst end.
- `mem_addr` out 32, `mem_read_op` out 3, `mem_write_op` out 2, `mem_wdata` out 32: memory request. `mem_rdata` in 32 is valid the cycle after a read is issued.

## Operation
- State machine states:
  - CPU: pass-through. `mem_*` = `cpu_*`, `cpu_rdata` = `mem_rdata`.
  - BURST: host owns memory; one word access per cycle.
  - TAIL: no memory op; final read word returns.
- CPU → BURST: taken when in CPU state, `host_req`=1 and `cpu_step`=EXEC.
  - Latch `host_we`, `{host_addr[31:2],2'b00}` into addr, `host_len` into remaining count.
  - If the latched length is 0, go to TAIL instead of BURST.
- BURST, each cycle:
  - Issue `mem_addr`=addr.
  - Reads: `mem_read_op`=LW, `mem_write_op`=SNONE.
  - Writes: `mem_write_op`=SW, `mem_wdata`=`host_wdata`, `host_wready`=1, `mem_read_op`=LNONE.
  - addr += 4, wrapping mod 2^32. Count decrements; after the issue with count==1, go to TAIL.
- `host_rvalid`=1 in the cycle after each read issue. `host_rdata` = `mem_rdata`. This overlaps into TAIL.
- TAIL: `host_done`=1, then CPU.
- `cpu_stall` = (state != CPU). It is decoded from the registered state only, with no combinational path from `host_req`.
- While stalled, CPU requests are ignored. `mem_*` come from the arbiter only: LNONE/SNONE in TAIL.
- `host_req` is ignored while `host_busy`.
- A `host_req` still high after `host_done` re-arms only at the next EXEC. At most one burst runs per CPU instruction.
- Reset mid-burst: return to CPU immediately. No `host_done`, count/addr cleared, memory write sequence truncated.

## Timing
- Reset values:
  - state=CPU, count=0, addr=0.
  - `cpu_stall`, `host_busy`, `host_wready`, `host_rvalid` and `host_done` = 0.
  - `mem_*` mirror `cpu_*`.
- Acceptance in EXEC cycle T:
  - `cpu_stall` and `host_busy` are high from T+1 through T+len+1.
  - First issue at T+1, last issue at T+len.
  - `host_done` at T+len+1.
  - CPU FETCH issues at T+len+2.
- len=0: stall and busy for T+1 only, `host_done` at T+1.
- CPU step stays at FETCH throughout. No CPU read is outstanding at takeover, because the EXEC-cycle capture of load data has already completed.
- Read data latency is 1 cycle. Write acceptance latency is 0 cycles (`host_wready` and the write are in the same cycle).

## Structure
- Step encodings and memory op codes (LW, SW, LNONE, SNONE) come from the shared `defs.inc`, which adds ARB_CPU, ARB_BURST and ARB_TAIL state encodings.
- No sub-module: state register, address register, counter and output mux fit one module.
- The CPU control's step counter gains a stall hold-enable input.

## Test plan
- Read burst, base 0x100, len 3, memory preloaded {0xA,0xB,0xC}, accepted at T:
  - `host_rvalid` at T+2..T+4 with 0xA, 0xB, 0xC.
  - `host_done` at T+4.
  - `cpu_stall` T+1..T+4.
  - CPU fetch at T+5 from unchanged pc.
- Write burst, base 0x203 (aligns to 0x200), len 2, data 0x11/0x22:
  - SW to 0x200 and 0x204 at T+1 and T+2.
  - `host_wready` at T+1 and T+2.
  - CPU read-back returns 0x11/0x22.
- `host_req` raised in DECODE: no acceptance until the EXEC of the same instruction. Request held through `host_done`: the next burst starts only after one full CPU instruction completes.
- len=0: single stall cycle, `host_done` at T+1, no memory op issued.
- Wrap: base 0xFFFFFFFC, len 2 → addresses 0xFFFFFFFC then 0x00000000.
- Reset asserted at T+2 of a len-4 write: next cycle `cpu_stall`=0, `host_busy`=0, no `host_done`, no further SW issued.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: CPU step codes, memory op codes
// and arbiter state encodings.
package mem_arbiter_pkg;

   localparam logic [1:0] STEP_FETCH  = 2'd0;
   localparam logic [1:0] STEP_DECODE = 2'd1;
   localparam logic [1:0] STEP_MEM    = 2'd2;
   localparam logic [1:0] STEP_EXEC   = 2'd3;

   localparam logic [2:0] LNONE = 3'd0;
   localparam logic [2:0] LW    = 3'd3;
   localparam logic [1:0] SNONE = 2'd0;
   localparam logic [1:0] SW    = 2'd3;

   typedef enum logic [1:0] {
      ARB_CPU   = 2'd0,
      ARB_BURST = 2'd1,
      ARB_TAIL  = 2'd2
   } arb_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Host burst port bundle: the loader/debug link is the master, the arbiter the slave.
interface mem_arbiter_if #(parameter int LEN_W = 8);

   logic             req;
   logic             we;
   logic [31:0]      addr;
   logic [LEN_W-1:0] len;
   logic [31:0]      wdata;
   logic             busy;
   logic             wready;
   logic             rvalid;
   logic [31:0]      rdata;
   logic             done;

   modport master (
      output req, we, addr, len, wdata,
      input  busy, wready, rvalid, rdata, done
   );

   modport slave (
      input  req, we, addr, len, wdata,
      output busy, wready, rvalid, rdata, done
   );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the memory port between the CPU and a host burst port; bursts are taken
// only at the EXEC step and freeze the CPU in FETCH until the burst completes.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  cpu_step,
   input  logic [31:0] cpu_addr,
   input  logic [2:0]  cpu_read_op,
   input  logic [1:0]  cpu_write_op,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   mem_arbiter_if.slave host,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_read_op,
   output logic [1:0]  mem_write_op,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   arb_state_e       state_r;
   logic [LEN_W-1:0] count_r;
   logic [31:0]      addr_r;
   logic             we_r;
   logic             rvalid_r;

   // Arbiter FSM with burst address/count sequencing and read-return flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ARB_CPU;
         count_r  <= CNT_ZERO;
         addr_r   <= 32'd0;
         we_r     <= 1'b0;
         rvalid_r <= 1'b0;
      end else begin
         rvalid_r <= (state_r == ARB_BURST) && !we_r;
         case (state_r)
            ARB_CPU: begin
               if (host.req && (cpu_step == STEP_EXEC)) begin
                  we_r    <= host.we;
                  addr_r  <= word_align(host.addr);
                  count_r <= host.len;
                  state_r <= (host.len == CNT_ZERO) ? ARB_TAIL : ARB_BURST;
               end
            end
            ARB_BURST: begin
               addr_r  <= addr_r + 32'd4;
               count_r <= count_r - CNT_ONE;
               // <= rather than == so a corrupted zero count still terminates.
               if (count_r <= CNT_ONE) begin
                  state_r <= ARB_TAIL;
               end
            end
            ARB_TAIL: begin
               state_r <= ARB_CPU;
            end
            default: begin
               state_r <= ARB_CPU;
            end
         endcase
      end
   end

   // Memory request mux: CPU pass-through unless the arbiter owns the port.
   always_comb begin
      mem_addr     = cpu_addr;
      mem_read_op  = cpu_read_op;
      mem_write_op = cpu_write_op;
      mem_wdata    = cpu_wdata;
      host.wready  = 1'b0;
      case (state_r)
         ARB_CPU: begin
            mem_addr     = cpu_addr;
            mem_read_op  = cpu_read_op;
            mem_write_op = cpu_write_op;
            mem_wdata    = cpu_wdata;
         end
         ARB_BURST: begin
            mem_addr = addr_r;
            if (we_r) begin
               mem_read_op  = LNONE;
               mem_write_op = SW;
               mem_wdata    = host.wdata;
               host.wready  = 1'b1;
            end else begin
               mem_read_op  = LW;
               mem_write_op = SNONE;
               mem_wdata    = 32'd0;
            end
         end
         ARB_TAIL: begin
            mem_addr     = addr_r;
            mem_read_op  = LNONE;
            mem_write_op = SNONE;
            mem_wdata    = 32'd0;
         end
         default: begin
            mem_addr     = addr_r;
            mem_read_op  = LNONE;
            mem_write_op = SNONE;
            mem_wdata    = 32'd0;
         end
      endcase
   end

   assign cpu_stall   = (state_r != ARB_CPU);
   assign host.busy   = (state_r != ARB_CPU);
   assign host.done   = (state_r == ARB_TAIL);
   assign host.rvalid = rvalid_r;
   assign host.rdata  = mem_rdata;
   assign cpu_rdata   = mem_rdata;

endmodule
